filter_sample_sequencer: RTL

FILTER_SAMPLE_SEQUENCER -- requirements
Module: filter_sample_sequencer

---
 rtl/filter_sample_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/filter_sample_sequencer.sv
// Sample-rate sequencer sitting between an upstream sample source and a
// filter engine. A programmable period timer paces the samples. Each tick
// pulls one sample, starts the filter, and captures the filter result.
// Ticks that arrive while a sample is still in flight are dropped and
// flagged. Ticks that find no upstream data are flagged too.
//
// state | meaning
// IDLE  | waiting for a period tick
// LOAD  | src_ready high, sample captured into filt_data_in at end of cycle
// TRIG  | one-cycle start pulse to the filter
// WAIT  | waiting (no timeout) for filter_done, result captured on exit
module filter_sample_sequencer #(
  parameter int DATA_SIZE = 24,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 clr_flags,
  input  logic [DATA_SIZE-1:0] src_data,
  input  logic                 src_valid,
  output logic                 src_ready,
  output logic                 sample_trig,
  output logic [DATA_SIZE-1:0] filt_data_in,
  input  logic                 filter_done,
  input  logic [DATA_SIZE-1:0] filt_data_out,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  output logic                 overrun,
  output logic                 underrun,
  output logic [15:0]          sample_count
);

  typedef enum logic [1:0] {IDLE, LOAD, TRIG, WAIT} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [DIV_WIDTH-1:0] period_cnt;
  logic [DIV_WIDTH-1:0] period_last;
  logic                 tick;
  logic                 finish;
  logic [15:0]          count_q;

  // Periods shorter than 2 cycles are not meaningful, so they run at 2
  assign period_last = (div < DIV_WIDTH'(2)) ? DIV_WIDTH'(1) : (div - DIV_WIDTH'(1));
  assign tick        = enable && (period_cnt == period_last);
  assign sample_count = count_q;

  // Period counter: runs 0..P-1 while enabled, parked at 0 otherwise.
  // Wrapping on >= keeps it bounded if div shrinks mid-period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_cnt <= '0;
    end else if (!enable) begin
      period_cnt <= '0;
    end else if (period_cnt >= period_last) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + DIV_WIDTH'(1);
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded handshake outputs
  always_comb begin
    state_nxt   = state;
    src_ready   = 1'b0;
    sample_trig = 1'b0;
    finish      = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        src_ready = 1'b1;
        state_nxt = TRIG;
      end
      TRIG: begin
        sample_trig = 1'b1;
        state_nxt   = WAIT;
      end
      WAIT: begin
        if (filter_done) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sample presented to the filter; held when upstream had nothing to give
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_data_in <= '0;
    end else if ((state == LOAD) && src_valid) begin
      filt_data_in <= src_data;
    end
  end

  // Result capture, completion pulse and completed-sample counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      count_q   <= '0;
    end else begin
      out_valid <= finish;
      if (finish) begin
        out_data <= filt_data_out;
        count_q  <= count_q + 16'd1;
      end
    end
  end

  // Sticky flags; a new event in the same cycle wins over the clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (tick && (state != IDLE)) begin
        overrun <= 1'b1;
      end else if (clr_flags) begin
        overrun <= 1'b0;
      end
      if ((state == LOAD) && !src_valid) begin
        underrun <= 1'b1;
      end else if (clr_flags) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule
